// File: rtl/wb_pkg.sv
// Shared encodings and the held-entry type for the RV32I writeback stage.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_REGW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Sized by the package widths; the stage parameters default to these.
    typedef struct packed {
        logic               we;
        logic [WB_REGW-1:0] rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load result formatting: byte/halfword extraction from the aligned word with
// sign or zero extension selected by funct3.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: result select, load formatting, x0 suppression and a
// two-entry OUT/SKID buffer. Optional retire counter under WB_RETIRE_CNT_EN.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int REGW = WB_REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic [REGW-1:0] in_rd,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_load,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rf_we,
    output logic [REGW-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid holds with its payload until that edge, and ready
    // never depends combinationally on valid.

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] sel_data;
    wb_entry_t       new_entry;
    wb_entry_t       out_q;
    wb_entry_t       skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            accept;
    logic            retire;

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .word    (in_load),
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .data    (load_data)
    );

    always_comb begin
        sel_data = in_alu;
        case (in_sel)
            WB_SEL_LOAD: sel_data = load_data;
            WB_SEL_PC4:  sel_data = in_pc4;
            WB_SEL_IMM:  sel_data = in_imm;
            default:     sel_data = in_alu;
        endcase
        new_entry.we   = in_we && (in_rd != '0);
        new_entry.rd   = in_rd;
        new_entry.data = sel_data;
    end

    assign accept = in_valid && in_ready;
    assign retire = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (retire) begin
            // A full SKID means in_ready was low, so no accept can coincide.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q <= new_entry;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_q       <= new_entry;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= new_entry;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign rf_we     = out_valid_q && out_q.we;
    assign rf_waddr  = out_q.rd;
    assign rf_wdata  = out_q.data;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= 64'd0;
        end else if (retire && !flush) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; retire_cnt checks are
// included when WB_RETIRE_CNT_EN is defined.
module tb_writeback_stage;
    import wb_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_load;
    logic [31:0] in_pc4;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        out_valid;
    logic        out_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {we, rd, data}.
    logic [37:0] exp_q[$];

    logic [2:0]  ld_f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
    logic [1:0]  ld_alo [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] ld_exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                32'h80FF_7F01, 32'h0000_007F, 32'h80FF_7F01};

    writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_we      (in_we),
        .in_rd      (in_rd),
        .in_sel     (in_sel),
        .in_alu     (in_alu),
        .in_load    (in_load),
        .in_pc4     (in_pc4),
        .in_imm     (in_imm),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_insn(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [2:0] f3, input logic [1:0] alo);
        in_we      = we;
        in_rd      = rd;
        in_sel     = sel;
        in_funct3  = f3;
        in_addr_lo = alo;
    endtask

    task automatic step(input logic v, input logic ordy, input logic fl);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rf_we"},     64'(rf_we),     64'd0);
        check({tag, "_rf_waddr"},  64'(rf_waddr),  64'd0);
        check({tag, "_rf_wdata"},  64'(rf_wdata),  64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
`ifdef WB_RETIRE_CNT_EN
        check({tag, "_retire_cnt"}, retire_cnt, 64'd0);
`endif
    endtask

    // scoreboard: inputs are stable at the falling edge, so this sees exactly
    // the retire condition the next rising edge will act on
    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_retire", 64'(exp_q.size()), 64'd1);
            else
                check("sb_retire", 64'({rf_we, rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_alu = '0;
        in_load = '0;
        in_pc4 = '0;
        in_imm = '0;
        set_insn(1'b0, 5'd0, WB_SEL_ALU, 3'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        // basic ALU write
        in_alu = 32'h0000_1234;
        set_insn(1'b1, 5'd5, WB_SEL_ALU, 3'd0, 2'd0);
        exp_q.push_back({1'b1, 5'd5, 32'h0000_1234});
        step(1'b1, 1'b1, 1'b0);
        check("alu_out_valid", 64'(out_valid), 64'd1);
        check("alu_rf_we",     64'(rf_we),     64'd1);
        check("alu_rf_waddr",  64'(rf_waddr),  64'd5);
        check("alu_rf_wdata",  64'(rf_wdata),  64'h0000_1234);
        check("alu_in_ready",  64'(in_ready),  64'd1);

        // loads, back to back
        in_load = 32'h80FF_7F01;
        for (int i = 0; i < 7; i++) begin
            set_insn(1'b1, 5'(10 + i), WB_SEL_LOAD, ld_f3[i], ld_alo[i]);
            exp_q.push_back({1'b1, 5'(10 + i), ld_exp[i]});
            step(1'b1, 1'b1, 1'b0);
            check("load_data", 64'(rf_wdata), 64'(ld_exp[i]));
        end

        in_pc4 = 32'h0000_0104;
        set_insn(1'b1, 5'd1, WB_SEL_PC4, 3'd0, 2'd0);
        exp_q.push_back({1'b1, 5'd1, 32'h0000_0104});
        step(1'b1, 1'b1, 1'b0);
        check("pc4_data", 64'(rf_wdata), 64'h0000_0104);

        // x0 suppression
        in_imm = 32'hDEAD_B000;
        set_insn(1'b1, 5'd0, WB_SEL_IMM, 3'd0, 2'd0);
        exp_q.push_back({1'b0, 5'd0, 32'hDEAD_B000});
        step(1'b1, 1'b1, 1'b0);
        check("x0_out_valid", 64'(out_valid), 64'd1);
        check("x0_rf_we",     64'(rf_we),     64'd0);
        check("imm_data",     64'(rf_wdata),  64'hDEAD_B000);
`ifdef WB_RETIRE_CNT_EN
        check("cnt_before_x0_retire", retire_cnt, 64'd9);
`endif
        step(1'b0, 1'b1, 1'b0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("cnt_after_x0_retire", retire_cnt, 64'd10);
`endif

        // stall: A to OUT, B to SKID, C held
        in_sel = WB_SEL_ALU;
        in_alu = 32'h0000_AAAA; in_rd = 5'd2;
        exp_q.push_back({1'b1, 5'd2, 32'h0000_AAAA});
        step(1'b1, 1'b0, 1'b0);
        check("stall_a_in_ready", 64'(in_ready), 64'd1);
        check("stall_a_waddr",    64'(rf_waddr), 64'd2);
        in_alu = 32'h0000_BBBB; in_rd = 5'd3;
        exp_q.push_back({1'b1, 5'd3, 32'h0000_BBBB});
        step(1'b1, 1'b0, 1'b0);
        check("stall_b_in_ready", 64'(in_ready), 64'd0);
        check("stall_b_waddr",    64'(rf_waddr), 64'd2);
        in_alu = 32'h0000_CCCC; in_rd = 5'd4;
        exp_q.push_back({1'b1, 5'd4, 32'h0000_CCCC});
        step(1'b1, 1'b0, 1'b0);
        check("stall_c_in_ready",  64'(in_ready),  64'd0);
        check("stall_c_out_valid", 64'(out_valid), 64'd1);
        check("stall_c_waddr",     64'(rf_waddr),  64'd2);
        step(1'b1, 1'b1, 1'b0);
        check("skid_move_waddr",    64'(rf_waddr), 64'd3);
        check("skid_move_wdata",    64'(rf_wdata), 64'h0000_BBBB);
        check("skid_move_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 1'b1, 1'b0);
        check("replace_waddr",     64'(rf_waddr),  64'd4);
        check("replace_out_valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b1, 1'b0);
        check("stall_drain_out_valid", 64'(out_valid), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("cnt_after_stall", retire_cnt, 64'd13);
`endif

        // flush with both entries full
        in_alu = 32'h0000_DDDD; in_rd = 5'd6;
        step(1'b1, 1'b0, 1'b0);
        in_alu = 32'h0000_EEEE; in_rd = 5'd7;
        step(1'b1, 1'b0, 1'b0);
        check("pre_flush_in_ready", 64'(in_ready), 64'd0);
        in_alu = 32'h0000_FFFF; in_rd = 5'd8;
        step(1'b1, 1'b1, 1'b1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
`ifdef WB_RETIRE_CNT_EN
        check("flush_cnt", retire_cnt, 64'd13);
`endif
        step(1'b0, 1'b1, 1'b0);
        check("post_flush_out_valid", 64'(out_valid), 64'd0);

        // asynchronous reset in the middle of a stall
        in_alu = 32'h0000_1111; in_rd = 5'd9;
        step(1'b1, 1'b0, 1'b0);
        in_alu = 32'h0000_2222; in_rd = 5'd11;
        step(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // stage is usable again after reset
        in_alu = 32'h0000_0055; in_rd = 5'd12; in_we = 1'b1;
        exp_q.push_back({1'b1, 5'd12, 32'h0000_0055});
        step(1'b1, 1'b1, 1'b0);
        check("post_reset_waddr", 64'(rf_waddr), 64'd12);
        check("post_reset_wdata", 64'(rf_wdata), 64'h0000_0055);
        step(1'b0, 1'b1, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        check("post_reset_cnt", retire_cnt, 64'd1);
`endif
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised writeback stage for the RV32I pipeline: it accepts a completed instruction from MEM, selects and formats the result, and drives the register-file write port. It extends the plain writeback register with several additions:
- result-source selection;
- load byte/halfword extraction with sign/zero extension;
- x0 write suppression;
- a valid/ready handshake with a 2-entry skid buffer and flush.

It sits between the MEM stage and the register file / commit logic.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register-address width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all held entries
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept
- in_we  in  1  instruction writes rd
- in_rd  in  REGW  destination register
- in_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
- in_alu / in_load / in_pc4 / in_imm  in  XLEN each  candidate results (in_load = raw aligned memory word)
- in_funct3  in  3  load size/sign
- in_addr_lo  in  2  load byte offset
- out_valid  out  1  write pending at register file
- out_ready  in  1  register file / commit accepts
- rf_we  out  1  write enable of pending entry
- rf_waddr  out  REGW  write address
- rf_wdata  out  XLEN  write data
- retire_cnt  out  64  retired count (only with WB_RETIRE_CNT_EN)

## Operation
- **Result select.** By in_sel at accept time. The LOAD path goes through load extraction:
  - 000 LB: byte at in_addr_lo, sign-extended.
  - 100 LBU: byte at in_addr_lo, zero-extended.
  - 001 LH: half at in_addr_lo[1], sign-extended.
  - 101 LHU: half at in_addr_lo[1], zero-extended.
  - 010 LW: in_addr_lo ignored.
  - Other funct3 values: word passed unchanged.
- **x0 suppression.** The stored write enable is in_we && (in_rd != 0). An instruction with rd = 0 still occupies a slot and retires.
- **Storage.** Two entries: OUT (drives rf_*/out_valid) and SKID.
- **Accept.** Occurs when in_valid && in_ready.
  - Goes to OUT if OUT is empty, or if OUT retires this cycle while SKID is empty.
  - Otherwise goes to SKID.
- **Retire.** Occurs when out_valid && out_ready. On retire, SKID (if full) moves to OUT. Order is always preserved.
- **in_ready.** Registered; equals "SKID empty".
- **Flush.** Has priority over everything. At the next edge OUT and SKID are empty and in_valid is ignored. No retire is counted in a flush cycle, even if out_ready is high.

## Timing
- Reset values: out_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=1, retire_cnt=0. Reset is asserted asynchronously; it is released synchronously to clk by the reset source.
- Latency: accepted at edge N → rf_* valid after edge N (1 cycle).
- Throughput: 1 per cycle while out_ready=1.
- When out_ready=0 with OUT full, the stage absorbs one more entry; in_ready drops after that edge.
- When OUT retires and SKID is full at the same edge, SKID moves to OUT and in_ready returns to 1 after the edge. An accept in the same cycle is impossible because in_ready was 0.
- Simultaneous accept and retire with SKID empty: the new entry replaces OUT, and out_valid stays 1.
- Reset mid-stall: all entries are lost and no write is issued.

## Configuration
- WB_RETIRE_CNT_EN **defined**:
  - retire_cnt port present.
  - Counter increments by 1 on each retire, including rd = 0 and rf_we = 0 entries.
  - Wraps modulo 2^64.
  - Cleared only by reset, not by flush.
- WB_RETIRE_CNT_EN **undefined**: retire_cnt port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package wb_pkg holds:
  - result-select encodings (WB_SEL_ALU/LOAD/PC4/IMM);
  - load funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - the entry typedef (we, rd, data).
- One combinational sub-module, wb_load_align (inputs: word, funct3, addr_lo; output: XLEN data).
- Top level contains the select mux, the OUT/SKID registers, and the optional counter.

## Test plan
- Reset released, then in_valid with sel=ALU, in_alu=0x0000_1234, rd=5, we=1, out_ready=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; in_ready stays 1.
- Loads with in_load=0x80FF_7F01 → expected rf_wdata:
  - LB, addr_lo=3: 0xFFFF_FF80
  - LBU, addr_lo=3: 0x0000_0080
  - LH, addr_lo=2: 0xFFFF_80FF
  - LHU, addr_lo=0: 0x0000_7F01
  - LW: 0x80FF_7F01
- rd=0, we=1, sel=IMM, in_imm=0xDEAD_B000 → out_valid=1 and rf_we=0; retire_cnt increments by 1.
- out_ready=0 with 3 back-to-back in_valid (A, B, C) → A in OUT, B in SKID, in_ready=0 and C held; then out_ready=1 → A, B, C retire in order on consecutive cycles.
- OUT and SKID full, flush=1 with out_ready=1 and in_valid=1 → next cycle out_valid=0, in_ready=1, retire_cnt unchanged.
- Reset asserted asynchronously mid-stall → all outputs immediately at reset values; retire_cnt=0.
